// File: rtl/md_sched.sv
// Multiply/divide sequencer: holds one mult/div for a fixed occupancy, then commits HI/LO.
// Define MD_SCHED_DIV_EN to build the divider; without it div/divu starts are ignored.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    input  logic        hilo_we,
    input  logic        hilo_sel,
    input  logic [31:0] hilo_wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [7:0] MULT_N = MULT_CYCLES[7:0];
    localparam logic [7:0] DIV_N  = DIV_CYCLES[7:0];

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [63:0] pending;
    logic        fast;
    logic [63:0] res;
    logic [7:0]  n_load;
    logic        op_ok;
    logic        commit;
    logic        accept;

`ifdef MD_SCHED_DIV_EN
    logic signed [31:0] q_s, r_s;
`endif

    always_comb begin
        res    = '0;
        n_load = op[1] ? DIV_N : MULT_N;
        op_ok  = 1'b1;
`ifdef MD_SCHED_DIV_EN
        q_s    = '0;
        r_s    = '0;
`endif
        case (op)
            2'd0: res = {{32{num1[31]}}, num1} * {{32{num2[31]}}, num2};
            2'd1: res = {32'h0, num1} * {32'h0, num2};
`ifdef MD_SCHED_DIV_EN
            2'd2: begin
                // Both corner cases are pinned explicitly rather than left to the divider.
                if (num2 == 32'h0)
                    res = {num1, 32'hFFFF_FFFF};
                else if (num1 == 32'h8000_0000 && num2 == 32'hFFFF_FFFF)
                    res = {32'h0, 32'h8000_0000};
                else begin
                    q_s = $signed(num1) / $signed(num2);
                    r_s = $signed(num1) % $signed(num2);
                    res = {r_s, q_s};
                end
            end
            default: begin
                if (num2 == 32'h0)
                    res = {num1, 32'hFFFF_FFFF};
                else
                    res = {num1 % num2, num1 / num2};
            end
`else
            default: op_ok = 1'b0;
`endif
        endcase
    end

    // A single-cycle op commits from IDLE one edge after acceptance via the fast flag.
    assign commit = fast | (state == RUN && cnt == 8'd1);
    assign accept = start & op_ok & (state == IDLE | commit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= '0;
            fast    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            fast <= 1'b0;
            if (commit) begin
                hi   <= pending[63:32];
                lo   <= pending[31:0];
                done <= 1'b1;
            end
            if (accept) begin
                pending <= res;
                if (n_load == 8'd1) begin
                    cnt   <= '0;
                    fast  <= 1'b1;
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    cnt   <= n_load;
                    state <= RUN;
                    busy  <= 1'b1;
                end
            end else if (state == RUN) begin
                cnt <= cnt - 8'd1;
                if (cnt == 8'd1) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else if (hilo_we && !start) begin
                // Placed after the commit so a write lands on top of a same-edge fast commit.
                if (hilo_sel)
                    hi <= hilo_wdata;
                else
                    lo <= hilo_wdata;
            end
        end
    end
endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: expected HI/LO queued at issue, checked by a done-driven monitor.
module tb_md_sched;
    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] num1, num2;
    logic        hilo_we, hilo_sel;
    logic [31:0] hilo_wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q[$];

    md_sched dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .num1(num1), .num2(num2),
        .hilo_we(hilo_we), .hilo_sel(hilo_sel), .hilo_wdata(hilo_wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (rst && done) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got hi=%h lo=%h expected no commit", hi, lo);
            end else begin
                chk("commit_hilo", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int n);
        int c;
        @(negedge clk);
        start = 1'b1; op = o; num1 = a; num2 = b;
        exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (busy && c < 300) begin
            c++;
            @(negedge clk);
        end
        chk("busy_len", 64'(c), 64'(n));
        chk("done_pulse", 64'(done), 64'd1);
        @(negedge clk);
        chk("done_clear", 64'(done), 64'd0);
    endtask

    initial begin
        int c;
        rst = 1'b0; start = 1'b0; op = 2'd0; num1 = '0; num2 = '0;
        hilo_we = 1'b0; hilo_sel = 1'b0; hilo_wdata = '0;
        repeat (2) @(negedge clk);
        chk("reset_state", {hi, lo}, 64'h0);
        chk("reset_ctl", {62'h0, busy, done}, 64'h0);
        rst = 1'b1;

        issue(2'd0, 32'd3, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, 5);
        issue(2'd1, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 5);
`ifdef MD_SCHED_DIV_EN
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 10);
        issue(2'd3, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF, 10);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 10);
        issue(2'd3, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 10);
        issue(2'd2, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 10);
`endif

        // Start and mtlo while busy must both be ignored.
        @(negedge clk);
        start = 1'b1; op = 2'd0; num1 = 32'd2; num2 = 32'd2;
        exp_q.push_back(64'h0000_0000_0000_0004);
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; op = 2'd1; num1 = 32'd5; num2 = 32'd5;
        @(negedge clk); start = 1'b0; hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'h1234;
        @(negedge clk); hilo_we = 1'b0;
        c = 0;
        while (busy && c < 300) begin
            c++;
            @(negedge clk);
        end
        chk("busy_ignored_start", 64'(c), 64'd2);
        @(negedge clk);
        chk("ignored_final", {hi, lo}, 64'h0000_0000_0000_0004);
        chk("ignored_idle", 64'(busy), 64'd0);

        // mthi in IDLE.
        hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        hilo_we = 1'b0;
        chk("mthi", {hi, lo}, 64'hDEAD_BEEF_0000_0004);
        chk("mthi_no_done", 64'(done), 64'd0);

        // Reset mid-operation clears everything at once.
        @(negedge clk);
`ifdef MD_SCHED_DIV_EN
        start = 1'b1; op = 2'd2; num1 = 32'd100; num2 = 32'd3;
`else
        start = 1'b1; op = 2'd0; num1 = 32'd100; num2 = 32'd3;
`endif
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_before_rst", 64'(busy), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_hilo", {hi, lo}, 64'h0);
        chk("rst_async_ctl", {62'h0, busy, done}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        issue(2'd0, 32'd6, 32'd7, 64'h0000_0000_0000_002A, 5);

`ifndef MD_SCHED_DIV_EN
        // Without the divider a divu start is dropped.
        @(negedge clk);
        start = 1'b1; op = 2'd3; num1 = 32'd9; num2 = 32'd3;
        @(negedge clk); start = 1'b0;
        chk("nodiv_busy", 64'(busy), 64'd0);
        repeat (12) @(negedge clk);
        chk("nodiv_hilo", {hi, lo}, 64'h0000_0000_0000_002A);
        chk("nodiv_done", 64'(done), 64'd0);
`endif

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
